// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for pipeline_sequencer: FSM state encoding,
// counter widths and the fixed control-output patterns.
package pipe_seq_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    HALT
  } seq_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_stall;
    logic if_flush;
    logic noop;
    logic stall_all;
  } ctrl_t;

  localparam ctrl_t IDLE_CTRL   = '{pc_write: 1'b0, if_stall: 1'b1, if_flush: 1'b0,
                                    noop: 1'b1, stall_all: 1'b0};
  localparam ctrl_t RUN_CTRL    = '{pc_write: 1'b1, if_stall: 1'b0, if_flush: 1'b0,
                                    noop: 1'b0, stall_all: 1'b0};
  localparam ctrl_t FREEZE_CTRL = '{pc_write: 1'b0, if_stall: 1'b1, if_flush: 1'b0,
                                    noop: 1'b0, stall_all: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination
// (other than x0) is read by the instruction in ID.
module load_use_detect (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  always_comb begin
    hazard_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
               ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: stall/flush/freeze arbitration with a data-memory
// timeout fault. Define PIPE_SEQ_PERF_CNT_EN to build the performance counters.
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_MemRead_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             PCWrite_o,
  output logic             IF_stall_o,
  output logic             IF_flush_o,
  output logic             NoOp_o,
  output logic             stall_all_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  ctrl_t             ctrl;
  logic              load_use;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (EX_MemRead_i),
    .ex_rd_i       (EX_rd_i),
    .id_rs1_i      (ID_rs1_i),
    .id_rs2_i      (ID_rs2_i),
    .hazard_o      (load_use)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl    = IDLE_CTRL;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        ctrl = RUN_CTRL;
        if (mem_busy_i) begin
          ctrl    = FREEZE_CTRL;
          wait_d  = WAIT_W'(1);
          state_d = MEM_WAIT;
        end else begin
          // Load-use outranks branch: stalling keeps the branch in ID, so no flush yet
          if (load_use) begin
            ctrl.pc_write = 1'b0;
            ctrl.if_stall = 1'b1;
            ctrl.noop     = 1'b1;
          end else if (branch_taken_i) begin
            ctrl.if_flush = 1'b1;
          end
          if (!start_i) state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        ctrl = FREEZE_CTRL;
        if (!mem_busy_i) begin
          wait_d  = '0;
          state_d = RUN;
        end else if (wait_q == TIMEOUT_CNT) begin
          state_d = HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT: begin
        ctrl = FREEZE_CTRL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign PCWrite_o   = ctrl.pc_write;
  assign IF_stall_o  = ctrl.if_stall;
  assign IF_flush_o  = ctrl.if_flush;
  assign NoOp_o      = ctrl.noop;
  assign stall_all_o = ctrl.stall_all;
  assign err_o       = (state_q == HALT);

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != IDLE) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (((state_q == RUN) || (state_q == MEM_WAIT)) && !ctrl.pc_write)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ctrl.if_flush) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign cycle_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer against a run/wait/halt
// behavioural model driven by busy-streak counting.
module tb_pipeline_sequencer;

  localparam int unsigned TO = 16;
`ifdef PIPE_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {PCWrite, IF_stall, IF_flush, NoOp, stall_all, err}
  localparam logic [5:0] O_IDLE   = 6'b010100;
  localparam logic [5:0] O_RUN    = 6'b100000;
  localparam logic [5:0] O_BRANCH = 6'b101000;
  localparam logic [5:0] O_LU     = 6'b010100;
  localparam logic [5:0] O_FREEZE = 6'b010010;
  localparam logic [5:0] O_HALT   = 6'b010011;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, EX_MemRead_i, branch_taken_i, mem_busy_i;
  logic [4:0]  ID_rs1_i, ID_rs2_i, EX_rd_i;
  logic        PCWrite_o, IF_stall_o, IF_flush_o, NoOp_o, stall_all_o, err_o;
  logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model state
  bit          m_run, m_wait, m_halt;
  int unsigned m_streak;
  logic [31:0] m_cyc, m_stl, m_fl;
  logic [5:0]  e_out;

  pipeline_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .ID_rs1_i       (ID_rs1_i),
    .ID_rs2_i       (ID_rs2_i),
    .EX_rd_i        (EX_rd_i),
    .EX_MemRead_i   (EX_MemRead_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .PCWrite_o      (PCWrite_o),
    .IF_stall_o     (IF_stall_o),
    .IF_flush_o     (IF_flush_o),
    .NoOp_o         (NoOp_o),
    .stall_all_o    (stall_all_o),
    .err_o          (err_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  function automatic logic [5:0] obs();
    return {PCWrite_o, IF_stall_o, IF_flush_o, NoOp_o, stall_all_o, err_o};
  endfunction

  function automatic logic [95:0] obs_cnt();
    return {cycle_cnt_o, stall_cnt_o, flush_cnt_o};
  endfunction

  function automatic logic [95:0] exp_cnt();
    return PERF ? {m_cyc, m_stl, m_fl} : 96'd0;
  endfunction

  task automatic set_in(input bit start, input bit busy, input bit memrd,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit br);
    start_i = start; mem_busy_i = busy; EX_MemRead_i = memrd;
    EX_rd_i = rd; ID_rs1_i = rs1; ID_rs2_i = rs2; branch_taken_i = br;
  endtask

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_halt = 0; m_streak = 0;
    m_cyc = '0; m_stl = '0; m_fl = '0;
  endtask

  task automatic model_eval();
    bit hz;
    hz = EX_MemRead_i && (EX_rd_i != 0) && (EX_rd_i == ID_rs1_i || EX_rd_i == ID_rs2_i);
    if (rst_i || !m_run)          e_out = O_IDLE;
    else if (m_halt)              e_out = O_HALT;
    else if (m_wait || mem_busy_i) e_out = O_FREEZE;
    else if (hz)                  e_out = O_LU;
    else if (branch_taken_i)      e_out = O_BRANCH;
    else                          e_out = O_RUN;
  endtask

  // Advance the model across one rising edge (reset released).
  task automatic model_step();
    if (m_run) m_cyc++;
    if (m_run && !m_halt && !e_out[5]) m_stl++;
    if (e_out[3]) m_fl++;
    if (m_halt) begin
    end else if (!m_run) begin
      m_run = start_i;
    end else if (mem_busy_i) begin
      m_streak++;
      m_wait = 1;
      if (m_streak == TO + 1) m_halt = 1;
    end else begin
      m_streak = 0;
      if (m_wait) m_wait = 0;
      else m_run = start_i;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_in(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    model_reset();
    repeat (2) begin
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== e_out) $display("FAIL reset_outputs: got %b want %b", obs(), e_out);
      else passes++;
      checks++;
      if (obs_cnt() !== 96'd0) $display("FAIL reset_counters: got %h want 0", obs_cnt());
      else passes++;
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
  endtask

  task automatic test_start_delay();
    for (int c = 1; c <= 6; c++) begin
      set_in(c >= 3, 0, 0, 5'($urandom), 5'($urandom), 5'($urandom), 0);
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== e_out) $display("FAIL start_cycle%0d: got %b want %b", c, obs(), e_out);
      else passes++;
      if (c == 4) begin
        checks++;
        if (PCWrite_o !== 1'b1) $display("FAIL start_pcwrite_c4: got %b want 1", PCWrite_o);
        else passes++;
      end
      tick();
    end
  endtask

  task automatic test_load_use_branch();
    logic [4:0] rd [6] = '{5'd5, 5'd0, 5'd7, 5'd9, 5'd3, 5'd3};
    logic [4:0] r1 [6] = '{5'd1, 5'd0, 5'd7, 5'd2, 5'd4, 5'd3};
    logic [4:0] r2 [6] = '{5'd5, 5'd0, 5'd8, 5'd9, 5'd6, 5'd1};
    bit         mr [6] = '{1, 1, 1, 0, 1, 1};
    bit         br [6] = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, mr[i], rd[i], r1[i], r2[i], br[i]);
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== e_out) $display("FAIL hazard_vec%0d: got %b want %b", i, obs(), e_out);
      else passes++;
      tick();
    end
  endtask

  task automatic test_mem_wait(input int unsigned busy_len, input string tag);
    for (int c = 0; c < int'(busy_len) + 4; c++) begin
      set_in(1, c < int'(busy_len), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1));
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== e_out) $display("FAIL %s_c%0d: got %b want %b", tag, c, obs(), e_out);
      else passes++;
      tick();
    end
  endtask

  task automatic test_halt_hold();
    for (int c = 0; c < 8; c++) begin
      set_in(c[0], $urandom_range(0, 1), 1, 5'd2, 5'd2, 5'd2, 1);
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== O_HALT) $display("FAIL halt_hold_c%0d: got %b want %b", c, obs(), O_HALT);
      else passes++;
      tick();
    end
    @(negedge clk_i);
    rst_i = 1'b1; model_reset();
    #1;
    checks++;
    if (obs() !== O_IDLE) $display("FAIL halt_reset: got %b want %b", obs(), O_IDLE);
    else passes++;
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_async_reset_mid_wait();
    set_in(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_in(1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
      tick();
    end
    @(negedge clk_i); model_eval();
    checks++;
    if (obs() !== O_FREEZE) $display("FAIL mid_wait_frozen: got %b want %b", obs(), O_FREEZE);
    else passes++;
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs() !== O_IDLE) $display("FAIL async_reset_outputs: got %b want %b", obs(), O_IDLE);
    else passes++;
    checks++;
    if (obs_cnt() !== 96'd0) $display("FAIL async_reset_counters: got %h want 0", obs_cnt());
    else passes++;
    #1 rst_i = 1'b0;
    set_in(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    @(posedge clk_i); model_step(); #1;
    @(negedge clk_i); model_eval();
    checks++;
    if (obs() !== e_out) $display("FAIL post_reset_idle: got %b want %b", obs(), e_out);
    else passes++;
    tick();
  endtask

  task automatic test_perf_counters();
    @(negedge clk_i);
    rst_i = 1'b1; model_reset();
    #2 rst_i = 1'b0;
    set_in(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 5)  set_in(1, 0, 1, 5'd6, 5'd6, 5'd1, 0);
      else if (c == 7)       set_in(1, 0, 0, 5'd0, 5'd0, 5'd0, 1);
      else                   set_in(1, 0, 0, 5'd4, 5'd4, 5'd4, 0);
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== e_out) $display("FAIL perf_run_c%0d: got %b want %b", c, obs(), e_out);
      else passes++;
      tick();
    end
    set_in(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk_i);
    checks++;
    if (obs_cnt() !== (PERF ? {32'd10, 32'd2, 32'd1} : 96'd0))
      $display("FAIL perf_counts: got cyc=%0d stl=%0d fl=%0d want %0d/%0d/%0d", cycle_cnt_o,
               stall_cnt_o, flush_cnt_o, PERF ? 10 : 0, PERF ? 2 : 0, PERF ? 1 : 0);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    int unsigned burst = 0;
    for (int c = 0; c < 600; c++) begin
      if (burst == 0 && $urandom_range(0, 11) == 0) burst = $urandom_range(1, 20);
      set_in($urandom_range(0, 9) != 0, burst != 0, $urandom_range(0, 1),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0);
      if (burst != 0) burst--;
      @(negedge clk_i); model_eval();
      checks++;
      if (obs() !== e_out) $display("FAIL random_c%0d: got %b want %b", c, obs(), e_out);
      else passes++;
      checks++;
      if (obs_cnt() !== exp_cnt())
        $display("FAIL random_cnt_c%0d: got %h want %h", c, obs_cnt(), exp_cnt());
      else passes++;
      if ($urandom_range(0, 79) == 0) begin
        #1 rst_i = 1'b1;
        model_reset();
        burst = 0;
        #1 rst_i = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_start_delay();
    test_load_use_branch();
    test_mem_wait(TO, "busy16");
    test_mem_wait(TO + 1, "busy17");
    test_halt_hold();
    test_async_reset_mid_wait();
    test_perf_counters();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
